// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg : shared types and constants for the hazard controller    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0        = 5'd0;
  localparam int         CNT_W_DEFAULT = 32;

  // True when an IF/ID source operand actually reads the given destination.
  function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline-register taps and stall/flush controls     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface hazard_ctrl_if #(
  parameter int CNT_W = hazard_pkg::CNT_W_DEFAULT
) ();

  logic [4:0]       rs1_IR1;
  logic [4:0]       rs2_IR1;
  logic             rs1_used_IR1;
  logic             rs2_used_IR1;
  logic             MemRead_IR2;
  logic [4:0]       instb_IR2;
  logic             branch_taken_IR3;

  logic             PC_Write;
  logic             IR1_Write;
  logic             ctrl_bubble;
  logic             flush_IR1;
  logic             flush_IR2;
  logic             flush_IR3;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs1_IR1, rs2_IR1, rs1_used_IR1, rs2_used_IR1,
    output MemRead_IR2, instb_IR2, branch_taken_IR3,
    input  PC_Write, IR1_Write, ctrl_bubble,
    input  flush_IR1, flush_IR2, flush_IR3,
    input  stall_count, flush_count
  );

  modport slave (
    input  rs1_IR1, rs2_IR1, rs1_used_IR1, rs2_used_IR1,
    input  MemRead_IR2, instb_IR2, branch_taken_IR3,
    output PC_Write, IR1_Write, ctrl_bubble,
    output flush_IR1, flush_IR2, flush_IR3,
    output stall_count, flush_count
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : event counter that sticks at all-ones                  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         clear,
  input  wire logic         inc,
  output logic      [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl : load-use stall and taken-branch flush sequencing       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int FLUSH_HOLD = 1
) (
  input  wire logic  clk,
  input  wire logic  reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] HOLD_LOAD = 2'(FLUSH_HOLD);

  state_e     state_q, state_d;
  logic [1:0] hold_q, hold_d;

  logic load_use;
  logic pc_write, ir1_write, ctrl_bubble;
  logic flush_ir1, flush_ir2, flush_ir3;
  logic stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_count, flush_count;

  assign load_use = hz.MemRead_IR2 && (hz.instb_IR2 != REG_X0) &&
                    (src_hit(hz.rs1_used_IR1, hz.rs1_IR1, hz.instb_IR2) ||
                     src_hit(hz.rs2_used_IR1, hz.rs2_IR1, hz.instb_IR2));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    pc_write    = 1'b1;
    ir1_write   = 1'b1;
    ctrl_bubble = 1'b0;
    flush_ir1   = 1'b0;
    flush_ir2   = 1'b0;
    flush_ir3   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (reset) begin
      // Hold the pipeline empty until reset releases.
      pc_write    = 1'b0;
      ir1_write   = 1'b0;
      ctrl_bubble = 1'b1;
      flush_ir1   = 1'b1;
      flush_ir2   = 1'b1;
      flush_ir3   = 1'b1;
    end else if (hz.branch_taken_IR3) begin
      flush_ir1 = 1'b1;
      flush_ir2 = 1'b1;
      flush_ir3 = 1'b1;
      flush_inc = 1'b1;
      if (FLUSH_HOLD > 0) begin
        state_d = HOLD;
        hold_d  = HOLD_LOAD;
      end else begin
        state_d = RUN;
        hold_d  = 2'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_write    = 1'b0;
            ir1_write   = 1'b0;
            ctrl_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = STALL;
          end
        end
        // The load has moved on; IR2 may still show it, so never re-stall here.
        STALL: state_d = RUN;
        HOLD: begin
          if (hold_q <= 2'd1) begin
            state_d = RUN;
            hold_d  = 2'd0;
          end else begin
            hold_d = hold_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          hold_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      hold_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

  assign hz.PC_Write    = pc_write;
  assign hz.IR1_Write   = ir1_write;
  assign hz.ctrl_bubble = ctrl_bubble;
  assign hz.flush_IR1   = flush_ir1;
  assign hz.flush_IR2   = flush_ir2;
  assign hz.flush_IR3   = flush_ir3;
  assign hz.stall_count = stall_count;
  assign hz.flush_count = flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl : directed and randomized checks against a cycle model |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int CNT_W      = 3;
  localparam int FLUSH_HOLD = 1;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Reference model: cycles of suppression left, whether last cycle stalled, counts.
  int m_supp = 0;
  bit m_stalled = 1'b0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_HOLD(FLUSH_HOLD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  function automatic stim_t mk(input bit rst, input logic [4:0] rs1, input bit u1,
                               input logic [4:0] rs2, input bit u2, input bit mr,
                               input logic [4:0] rd, input bit br);
    stim_t s;
    s.rst = rst; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.mr = mr; s.rd = rd; s.br = br;
    return s;
  endfunction

  // Drives one cycle starting just after a rising edge; returns observed and expected
  // controls {PC_Write, IR1_Write, ctrl_bubble, flush_IR1, flush_IR2, flush_IR3} and counts.
  task automatic cycle(input stim_t s, output logic [5:0] obs, output logic [5:0] exp,
                       output logic [5:0] mask, output logic [CNT_W-1:0] osc,
                       output logic [CNT_W-1:0] ofc, output logic [CNT_W-1:0] esc,
                       output logic [CNT_W-1:0] efc);
    bit lu;
    reset               = s.rst;
    hz.rs1_IR1          = s.rs1;
    hz.rs2_IR1          = s.rs2;
    hz.rs1_used_IR1     = s.u1;
    hz.rs2_used_IR1     = s.u2;
    hz.MemRead_IR2      = s.mr;
    hz.instb_IR2        = s.rd;
    hz.branch_taken_IR3 = s.br;

    lu   = s.mr && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    mask = 6'b111111;
    if (s.rst) begin
      exp = 6'b001111;
      m_supp = 0; m_stalled = 1'b0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else if (s.br) begin
      exp  = 6'b100111;
      mask = 6'b100111;
      if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
      m_supp = FLUSH_HOLD;
      m_stalled = 1'b0;
    end else if (m_supp > 0 || m_stalled) begin
      exp = 6'b110000;
      if (m_supp > 0) m_supp--;
      m_stalled = 1'b0;
    end else if (lu) begin
      exp = 6'b001000;
      if (m_stall_cnt < CNT_MAX) m_stall_cnt++;
      m_stalled = 1'b1;
    end else begin
      exp = 6'b110000;
    end

    @(negedge clk);
    obs = {hz.PC_Write, hz.IR1_Write, hz.ctrl_bubble, hz.flush_IR1, hz.flush_IR2, hz.flush_IR3};
    @(posedge clk);
    #1;
    osc = hz.stall_count;
    ofc = hz.flush_count;
    esc = CNT_W'(m_stall_cnt);
    efc = CNT_W'(m_flush_cnt);
  endtask

  task automatic test_reset();
    logic [5:0] o, e, m;
    logic [CNT_W-1:0] osc, ofc, esc, efc;
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1, 5, 1, 5, 1, 1, 5, i == 1), o, e, m, osc, ofc, esc, efc);
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL reset_ctrl[%0d]: got %b want %b", i, o & m, e & m);
      end
      checks++;
      if (osc !== 0 || ofc !== 0) begin
        failures++; $display("FAIL reset_counts[%0d]: got %0d/%0d want 0/0", i, osc, ofc);
      end
    end
  endtask

  task automatic run_table(input string name, input stim_t q[$],
                           output logic [CNT_W-1:0] last_sc, output logic [CNT_W-1:0] last_fc);
    logic [5:0] o, e, m;
    logic [CNT_W-1:0] osc, ofc, esc, efc;
    last_sc = '0;
    last_fc = '0;
    foreach (q[i]) begin
      cycle(q[i], o, e, m, osc, ofc, esc, efc);
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL %s_ctrl[%0d]: got %b want %b", name, i, o & m, e & m);
      end
      checks++;
      if (osc !== esc || ofc !== efc) begin
        failures++;
        $display("FAIL %s_counts[%0d]: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 name, i, osc, ofc, esc, efc);
      end
      last_sc = osc;
      last_fc = ofc;
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    logic [CNT_W-1:0] sc, fc;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0));
    q.push_back(mk(0, 0, 0, 7, 1, 1, 7, 0));
    q.push_back(mk(0, 0, 0, 7, 1, 1, 7, 0));
    q.push_back(mk(0, 1, 1, 2, 1, 0, 0, 0));
    run_table("load_use", q, sc, fc);
    checks++;
    if (sc !== 3'd2) begin
      failures++; $display("FAIL load_use_total: got %0d want 2", sc);
    end
  endtask

  task automatic test_no_stall();
    stim_t q[$];
    logic [CNT_W-1:0] sc, fc;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0));
    q.push_back(mk(0, 3, 1, 9, 0, 1, 9, 0));
    q.push_back(mk(0, 3, 1, 4, 1, 1, 6, 0));
    q.push_back(mk(0, 6, 1, 6, 1, 0, 6, 0));
    run_table("no_stall", q, sc, fc);
    checks++;
    if (sc !== 3'd0) begin
      failures++; $display("FAIL no_stall_total: got %0d want 0", sc);
    end
  endtask

  task automatic test_branch();
    stim_t q[$];
    logic [CNT_W-1:0] sc, fc;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(0, 4, 1, 0, 0, 1, 4, 0));
    run_table("branch", q, sc, fc);
    checks++;
    if (sc !== 3'd1 || fc !== 3'd3) begin
      failures++; $display("FAIL branch_total: got stall=%0d flush=%0d want 1/3", sc, fc);
    end
  endtask

  task automatic test_simultaneous();
    stim_t q[$];
    logic [CNT_W-1:0] sc, fc;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 8, 0, 8, 1, 1, 8, 0));
    q.push_back(mk(0, 8, 0, 8, 1, 1, 8, 1));
    run_table("simultaneous", q, sc, fc);
    checks++;
    if (sc !== 3'd1 || fc !== 3'd2) begin
      failures++; $display("FAIL simultaneous_total: got stall=%0d flush=%0d want 1/2", sc, fc);
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t q[$];
    logic [CNT_W-1:0] sc, fc;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0));
    q.push_back(mk(1, 5, 1, 0, 0, 1, 5, 0));
    q.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0));
    run_table("reset_mid_stall", q, sc, fc);
    checks++;
    if (sc !== 3'd1 || fc !== 3'd0) begin
      failures++; $display("FAIL reset_mid_stall_total: got stall=%0d flush=%0d want 1/0", sc, fc);
    end
  endtask

  task automatic test_saturation();
    stim_t q[$];
    logic [CNT_W-1:0] sc, fc;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 18; i++) q.push_back(mk(0, 3, 1, 0, 0, 1, 3, 0));
    for (int i = 0; i < 9; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    run_table("saturation", q, sc, fc);
    checks++;
    if (sc !== 3'd7 || fc !== 3'd7) begin
      failures++; $display("FAIL saturation_total: got stall=%0d flush=%0d want 7/7", sc, fc);
    end
  endtask

  task automatic test_random();
    stim_t q[$];
    logic [CNT_W-1:0] sc, fc;
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 400; i++) begin
      q.push_back(mk($urandom_range(0, 59) == 0,
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                     $urandom_range(0, 6) == 0));
    end
    run_table("random", q, sc, fc);
  endtask

  initial begin
    hz.rs1_IR1 = '0; hz.rs2_IR1 = '0; hz.rs1_used_IR1 = 1'b0; hz.rs2_used_IR1 = 1'b0;
    hz.MemRead_IR2 = 1'b0; hz.instb_IR2 = '0; hz.branch_taken_IR3 = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_simultaneous();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
